sm83_alu_seq: RTL and testbench



---
 rtl/sm83_alu_pkg.sv | 23 ++
 rtl/sm83_alu_slice.sv | 35 +++
 rtl/sm83_alu_seq.sv | 103 ++++++++++
 tb/tb_sm83_alu_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sm83_alu_pkg.sv
// sm83_alu_pkg: shared operation encoding, flag layout and op-class helpers for the SM83 ALU.
package sm83_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP
    } alu_op_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    function automatic logic op_is_sub(alu_op_t op);
        return op inside {OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic op_is_logic(alu_op_t op);
        return op inside {OP_AND, OP_XOR, OP_OR};
    endfunction

endpackage

// File: rtl/sm83_alu_slice.sv
// sm83_alu_slice: combinational ripple slice; subtraction is A + ~B + carry.
module sm83_alu_slice
    import sm83_alu_pkg::*;
#(
    parameter int SLICE_WIDTH = 4
) (
    input  logic [SLICE_WIDTH-1:0] a,
    input  logic [SLICE_WIDTH-1:0] b,
    input  logic                   c_in,
    input  alu_op_t                op,
    output logic [SLICE_WIDTH-1:0] r,
    output logic                   c_out
);

    logic [SLICE_WIDTH-1:0] bb, g, p;
    logic [SLICE_WIDTH:0]   c;

    assign bb   = op_is_sub(op) ? ~b : b;
    assign g    = a & bb;
    assign p    = a ^ bb;
    assign c[0] = c_in;

    for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_chain
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end

    always_comb begin
        r = op == OP_AND ? a & b :
            op == OP_XOR ? a ^ b :
            op == OP_OR  ? a | b : p ^ c[SLICE_WIDTH-1:0];
    end

    assign c_out = op_is_logic(op) ? 1'b0 : c[SLICE_WIDTH];

endmodule

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: word-wide SM83 ALU evaluated one slice per clock, LSB first,
// with valid/ready handshakes on both sides.
module sm83_alu_seq
    import sm83_alu_pkg::*;
#(
    parameter int SLICE_WIDTH = 4,
    parameter int NUM_SLICES  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2:0]                        op,
    input  logic [SLICE_WIDTH*NUM_SLICES-1:0] a,
    input  logic [SLICE_WIDTH*NUM_SLICES-1:0] b,
    input  logic                              carry_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SLICE_WIDTH*NUM_SLICES-1:0] result,
    output logic [3:0]                        flags
);

    localparam int WS = SLICE_WIDTH * NUM_SLICES;
    localparam int IW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_n;
    alu_op_t                op_in, op_q;
    logic [WS-1:0]          a_q, b_q, res_q, res_n;
    logic [IW-1:0]          idx;
    logic [SLICE_WIDTH-1:0] s_r;
    logic                   s_c, carry_q, h_raw, h_now, accept;
    alu_flags_t             flags_q, flags_n;

    assign op_in     = alu_op_t'(op);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && accept)         state_n = RUN;
        if (state == RUN && idx == LAST)     state_n = DONE;
        if (state == DONE && out_ready)      state_n = IDLE;
    end

    sm83_alu_slice #(.SLICE_WIDTH(SLICE_WIDTH)) u_slice (
        .a     (a_q[idx*SLICE_WIDTH +: SLICE_WIDTH]),
        .b     (b_q[idx*SLICE_WIDTH +: SLICE_WIDTH]),
        .c_in  (carry_q),
        .op    (op_q),
        .r     (s_r),
        .c_out (s_c)
    );

    // Flags are formed from the word as it will look after the final slice is written.
    always_comb begin
        res_n                                = res_q;
        res_n[idx*SLICE_WIDTH +: SLICE_WIDTH] = s_r;
        h_now     = idx == '0 ? s_c : h_raw;
        flags_n.z = res_n == '0;
        flags_n.n = op_is_sub(op_q);
        flags_n.h = op_is_sub(op_q) ? !h_now : op_is_logic(op_q) ? op_q == OP_AND : h_now;
        flags_n.c = op_is_sub(op_q) ? !s_c : s_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            carry_q <= 1'b0;
            h_raw   <= 1'b0;
            idx     <= '0;
            flags_q <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op_in;
            idx     <= '0;
            carry_q <= op_in == OP_ADC ? carry_in : op_in == OP_SBC ? !carry_in : op_is_sub(op_in);
        end else if (state == RUN) begin
            res_q   <= res_n;
            carry_q <= s_c;
            h_raw   <= h_now;
            idx     <= idx == LAST ? '0 : idx + 1'b1;
            if (idx == LAST) flags_q <= flags_n;
        end
    end

    // CP keeps A as its visible result; the difference only feeds the flags.
    assign result = op_q == OP_CP ? a_q : res_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// tb_sm83_alu_seq: directed and randomized checks of the 8-bit and 16-bit configurations
// against an arithmetic reference model.
module tb_sm83_alu_seq;

    logic        clk = 1'b0, reset = 1'b1, iv = 1'b0, ordy = 1'b0, cin = 1'b0, wide = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = 16'h0, b = 16'h0;
    logic        ir8, ov8, ir16, ov16, ir, ov;
    logic [7:0]  r8;
    logic [15:0] r16, res;
    logic [3:0]  f8, f16, fl;
    int          nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    assign ir  = wide ? ir16 : ir8;
    assign ov  = wide ? ov16 : ov8;
    assign res = wide ? r16 : {8'h00, r8};
    assign fl  = wide ? f16 : f8;

    sm83_alu_seq u8 (
        .clk(clk), .reset(reset), .in_valid(iv && !wide), .in_ready(ir8), .op(op),
        .a(a[7:0]), .b(b[7:0]), .carry_in(cin), .out_valid(ov8), .out_ready(ordy && !wide),
        .result(r8), .flags(f8)
    );

    sm83_alu_seq #(.SLICE_WIDTH(4), .NUM_SLICES(4)) u16 (
        .clk(clk), .reset(reset), .in_valid(iv && wide), .in_ready(ir16), .op(op),
        .a(a), .b(b), .carry_in(cin), .out_valid(ov16), .out_ready(ordy && wide),
        .result(r16), .flags(f16)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        assert (got === exp)
        else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {z,n,h,c, result} computed directly from the arithmetic definition.
    function automatic logic [19:0] model(input int w, input logic [2:0] o,
                                          input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        int m, xa, ya, k, e, r;
        logic z, n, h, c;
        m = (1 << w) - 1;
        xa = int'(x) & m;
        ya = int'(y) & m;
        k = 0; n = 1'b0; h = 1'b0; c = 1'b0; r = 0;
        case (o)
            3'd0, 3'd1: begin
                k = (o == 3'd1) ? int'(ci) : 0;
                e = xa + ya + k;
                r = e & m;
                c = e > m;
                h = (xa % 16) + (ya % 16) + k > 15;
            end
            3'd2, 3'd3, 3'd7: begin
                k = (o == 3'd3) ? int'(ci) : 0;
                r = (xa - ya - k) & m;
                c = xa < ya + k;
                h = (xa % 16) < (ya % 16) + k;
                n = 1'b1;
            end
            3'd4: begin r = xa & ya; h = 1'b1; end
            3'd5: r = xa ^ ya;
            default: r = xa | ya;
        endcase
        z = r == 0;
        if (o == 3'd7) r = xa;
        return {z, n, h, c, 16'(r)};
    endfunction

    task automatic xact(input logic w, input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic ci, input logic [15:0] er,
                        input logic [3:0] ef, input int hold, input logic noise);
        int n;
        @(negedge clk);
        wide = w; op = o; a = x; b = y; cin = ci; iv = 1'b1; ordy = 1'b0;
        check("in_ready_idle", 16'(ir), 16'd1);
        @(posedge clk);
        n = 0;
        @(negedge clk);
        iv = noise;
        while (!ov && n < 20) begin
            if (noise) begin
                op = 3'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        iv = 1'b0;
        check("latency", 16'(n), w ? 16'd4 : 16'd2);
        check("result", res, er);
        check("flags", 16'(fl), 16'(ef));
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 16'(ov), 16'd1);
            check("hold_in_ready", 16'(ir), 16'd0);
            check("hold_result", res, er);
            check("hold_flags", 16'(fl), 16'(ef));
        end
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
        check("release_valid", 16'(ov), 16'd0);
        check("release_in_ready", 16'(ir), 16'd1);
    endtask

    initial begin
        logic [19:0] m;
        logic        w;
        logic [2:0]  o;
        logic [15:0] x, y;
        logic        ci;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready8", 16'(ir8), 16'd1);
        check("rst_out_valid8", 16'(ov8), 16'd0);
        check("rst_result8", 16'(r8), 16'd0);
        check("rst_flags8", 16'(f8), 16'd0);
        check("rst_in_ready16", 16'(ir16), 16'd1);
        check("rst_out_valid16", 16'(ov16), 16'd0);
        check("rst_result16", r16, 16'd0);
        check("rst_flags16", 16'(f16), 16'd0);
        reset = 1'b0;

        xact(1'b0, 3'd0, 16'h3A, 16'hC6, 1'b0, 16'h00, 4'b1011, 0, 1'b0);
        xact(1'b0, 3'd2, 16'h3E, 16'h0F, 1'b0, 16'h2F, 4'b0110, 0, 1'b0);
        xact(1'b0, 3'd3, 16'h3B, 16'h2A, 1'b1, 16'h10, 4'b0100, 0, 1'b0);
        xact(1'b0, 3'd4, 16'h5A, 16'h3F, 1'b0, 16'h1A, 4'b0010, 0, 1'b0);
        xact(1'b0, 3'd7, 16'h3C, 16'h40, 1'b0, 16'h3C, 4'b0101, 0, 1'b0);
        xact(1'b1, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1011, 0, 1'b0);
        xact(1'b1, 3'd1, 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 4'b0010, 0, 1'b0);
        xact(1'b0, 3'd0, 16'h12, 16'h34, 1'b0, 16'h46, 4'b0000, 5, 1'b1);

        // Abort in the first RUN cycle.
        @(negedge clk);
        wide = 1'b0; op = 3'd0; a = 16'h01; b = 16'h01; iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", 16'(ir8), 16'd1);
        check("abort_out_valid", 16'(ov8), 16'd0);
        check("abort_result", 16'(r8), 16'd0);
        check("abort_flags", 16'(f8), 16'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_pulse", 16'(ov8), 16'd0);
        end
        xact(1'b0, 3'd0, 16'h01, 16'h01, 1'b0, 16'h02, 4'b0000, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom);
            o  = 3'($urandom);
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom);
            if (i % 8 == 0) y = x;
            m = model(w ? 16 : 8, o, x, y, ci);
            xact(w, o, x, y, ci, m[15:0], m[19:16], int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
